spi_slave_sync: RTL and testbench
=================================

// Module: spi_slave_sync
// PURPOSE
//  Parametrised SPI slave, successor to the SCLK-clocked slave. Runs entirely in the system
//  clock domain: SCLK/CS_/MOSI are synchronised and edge-detected. Supports all four CPOL/CPHA
//  modes, configurable word width and bit order, and back-to-back words while CS_ stays low.
//  Buffered TX word with valid/ready handshake; RX words reported by a one-cycle strobe.
// PARAMETERS
//  DATA_WIDTH   8     bits per SPI word (>=2)
//  LSB_FIRST    1     1: bit 0 shifted first on MOSI and MISO; 0: MSB first
//  SYNC_STAGES  2     synchroniser flops on slaveSCLK, slaveCS_, slaveMOSI (>=2)
//  TX_FILL      0     word sent when no TX word is buffered at word start (DATA_WIDTH bits)
// PORTS
//  clk          in   1           system clock
//  reset_n      in   1           asynchronous reset, active low
//  slaveCPOL    in   1           clock polarity; static while slaveCS_ high
//  slaveCPHA    in   1           clock phase; static while slaveCS_ high
//  slaveSCLK    in   1           SPI clock (asynchronous)
//  slaveCS_     in   1           chip select, active low (asynchronous)
//  slaveMOSI    in   1           master-out data
//  slaveMISO    out  1           slave-out data
//  slaveMISO_oe out  1           1 while synchronised CS_ low; top level tri-states MISO
//  tx_data      in   DATA_WIDTH  next word to transmit
//  tx_valid     in   1           tx_data valid
//  tx_ready     out  1           TX buffer empty; transfer on tx_valid & tx_ready
//  rx_data      out  DATA_WIDTH  last complete received word
//  rx_valid     out  1           one-clk strobe: rx_data updated
//  tx_underrun  out  1           one-clk strobe: word started with empty buffer (TX_FILL sent)
//  busy         out  1           state != IDLE
// BEHAVIOUR
//  - Reset values: slaveMISO 0, slaveMISO_oe 0, tx_ready 1, rx_data 0, rx_valid 0,
//    tx_underrun 0, busy 0; TX buffer empty, bit counter 0, state IDLE.
//  - Timing req: SCLK high and low phases each >= SYNC_STAGES+2 clk. MISO changes
//    SYNC_STAGES+1 clk after the causing SCLK/CS_ edge.
//  - Leading edge = rising if CPOL=0 else falling. Sample edge = leading if CPHA=0 else
//    trailing; shift edge = the other one.
//  - States: IDLE -> LOAD on synchronised CS_ fall. LOAD (1 clk): shift-out reg <= buffer
//    (buffer freed, tx_ready 1 next clk) or TX_FILL with tx_underrun strobe; if CPHA=0
//    drive first bit onto MISO. -> SHIFT.
//  - SHIFT: on shift edge drive next bit (CPHA=1: first shift edge drives first bit);
//    on sample edge capture MOSI into shift-in reg, counter++.
//  - Counter reaching DATA_WIDTH: rx_data <= shift-in, rx_valid 1 clk, counter 0, reload
//    shift-out in the same clk as LOAD would (continuous words). CPHA=0: first bit of next
//    word driven on the closing shift edge of the previous word.
//  - CS_ rise at any point: -> IDLE next clk, oe 0, counter 0; partial word discarded, no
//    rx_valid; consumed TX word is not restored.
//  - tx_valid & tx_ready in the same clk as LOAD consumes: new word accepted only if buffer
//    was empty before that clk (LOAD uses old content; tx_ready low that clk, buffer empty).
//  - Sample and shift edges never coincide (distinct SCLK levels); CS_ fall with SCLK not at
//    CPOL idle level: edges ignored until SCLK returns to idle level.
//  - reset_n low mid-word: immediate return to reset values, no strobes.
// STRUCTURE
//  - spi_pkg: mode encoding constants (MODE0..MODE3), state enum (IDLE, LOAD, SHIFT).
//  - Sub-module spi_sync_edge: SYNC_STAGES synchroniser + rise/fall pulse outputs; instanced
//    for slaveSCLK and slaveCS_; MOSI uses plain synchroniser of equal depth (aligned).
//  - Top: FSM, bit counter ($clog2(DATA_WIDTH+1) bits), shift regs, TX buffer.
// TESTING
//  - Mode0, LSB_FIRST=1, tx 8'b00001111, MOSI 8'b10101010 -> master reads 00001111,
//    rx_data 10101010, single rx_valid after 8th rising SCLK.
//  - Modes 1/2/3 with tx 8'b11011000/01011001/00011011, MOSI 01110110/00000000/11111111
//    -> exact words both directions, MISO stable on each sample edge.
//  - Two words under one CS_ low, second tx loaded mid-first word -> two rx_valid strobes,
//    MISO shows both words back-to-back, tx_ready rises at each LOAD.
//  - No tx word buffered, TX_FILL=8'hA5 -> MISO sends A5, tx_underrun strobes once.
//  - CS_ rises after 5 bits -> no rx_valid, rx_data unchanged, next transfer correct.
//  - reset_n low mid-word then released -> all outputs at reset values; next mode0
//    transfer 8'h3C/8'hC3 completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the system-clocked SPI slave: mode encodings and FSM states.
package spi_pkg;

    // {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, with one-clk rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely in the system clock domain; all four CPOL/CPHA modes,
// back-to-back words under one CS_, buffered TX word and strobed RX word.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           LSB_FIRST   = 1,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_FILL     = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  slaveCPOL,
    input  logic                  slaveCPHA,
    input  logic                  slaveSCLK,
    input  logic                  slaveCS_,
    input  logic                  slaveMOSI,
    output logic                  slaveMISO,
    output logic                  slaveMISO_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int unsigned     CW   = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic mosi;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset_n(reset_n), .din(slaveSCLK),
        .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset_n(reset_n), .din(slaveCS_),
        .dout(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    // Same depth as the SCLK chain so a detected edge sees the MOSI level of that edge
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    always_comb mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], slaveMOSI};
    assign mosi = mosi_sync_q[SYNC_STAGES-1];

    spi_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic [DATA_WIDTH-1:0] shout_q, shout_d;
    logic [DATA_WIDTH-1:0] shin_q, shin_d;
    logic                  miso_q, miso_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic                  load_now;
    logic [DATA_WIDTH-1:0] load_word;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] drop_bit(input logic [DATA_WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    always_comb begin
        lead_edge  = slaveCPOL ? sclk_fall : sclk_rise;
        trail_edge = slaveCPOL ? sclk_rise : sclk_fall;
        case ({slaveCPOL, slaveCPHA})
            MODE0, MODE2: begin sample_edge = lead_edge;  shift_edge = trail_edge; end
            MODE1, MODE3: begin sample_edge = trail_edge; shift_edge = lead_edge;  end
            default:      begin sample_edge = 1'b0;       shift_edge = 1'b0;       end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        shout_d    = shout_q;
        shin_d     = shin_q;
        miso_d     = miso_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        load_now   = 1'b0;
        load_word  = buf_full_q ? buf_q : TX_FILL;

        if (state_q != IDLE && (cs_rise || cs_lvl)) begin
            state_d = IDLE;
            cnt_d   = '0;
            armed_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_d = LOAD;
                LOAD: begin
                    load_now = 1'b1;
                    cnt_d    = '0;
                    armed_d  = (sclk_lvl == slaveCPOL);
                    shout_d  = load_word;
                    if (!slaveCPHA) begin
                        miso_d  = first_bit(load_word);
                        shout_d = drop_bit(load_word);
                    end
                    state_d = SHIFT;
                end
                SHIFT: begin
                    // Edges only count once SCLK has been seen at its idle level
                    if (!armed_q) begin
                        armed_d = (sclk_lvl == slaveCPOL);
                    end else if (shift_edge) begin
                        miso_d  = first_bit(shout_q);
                        shout_d = drop_bit(shout_q);
                    end else if (sample_edge) begin
                        shin_d = (LSB_FIRST != 0) ? {mosi, shin_q[DATA_WIDTH-1:1]}
                                                  : {shin_q[DATA_WIDTH-2:0], mosi};
                        if (cnt_q == LAST) begin
                            // Reload holds the whole next word; the next shift edge drives its first bit
                            cnt_d      = '0;
                            rx_data_d  = shin_d;
                            rx_valid_d = 1'b1;
                            load_now   = 1'b1;
                            shout_d    = load_word;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (load_now) begin
            underrun_d = ~buf_full_q;
            if (buf_full_q) buf_full_d = 1'b0;
        end
        if (tx_valid && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            shout_q     <= '0;
            shin_q      <= '0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            mosi_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            shout_q     <= shout_d;
            shin_q      <= shin_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign slaveMISO    = miso_q;
    assign slaveMISO_oe = ~cs_lvl;
    assign tx_ready     = ~buf_full_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign tx_underrun  = underrun_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: bit-level SPI master with hand-computed words.
module tb_spi_slave_sync;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;

    int         rxv_cnt = 0, und_cnt = 0, rdy_rise = 0;
    logic [7:0] rx_log [0:3];
    logic       rdy_prev = 1'b1;

    spi_slave_sync #(
        .DATA_WIDTH(8), .LSB_FIRST(1), .SYNC_STAGES(2), .TX_FILL(8'hA5)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .slaveCPOL(cpol), .slaveCPHA(cpha), .slaveSCLK(sclk), .slaveCS_(cs_n),
        .slaveMOSI(mosi), .slaveMISO(miso), .slaveMISO_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rxv_cnt % 4] = rx_data;
            rxv_cnt++;
        end
        if (tx_underrun) und_cnt++;
        if (tx_ready && !rdy_prev) rdy_rise++;
        rdy_prev = tx_ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] w);
        int n = 0;
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check("tx_push_accepted", (n < 400) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic half_wait(output logic pre);
        #(HALF - 20);
        pre = miso;
        #20;
    endtask

    // Bit i of mosi_bits is the i-th bit on the wire; miso_bits collected the same way.
    task automatic spi_xfer(input logic m_cpol, input logic m_cpha, input int nbits,
                            input logic [15:0] mosi_bits, input bit release_cs,
                            output logic [15:0] miso_bits, output int unstable);
        logic pre;
        miso_bits = '0;
        unstable  = 0;
        cpol = m_cpol;
        cpha = m_cpha;
        sclk = m_cpol;
        #(HALF);
        cs_n = 1'b0;
        if (!m_cpha) mosi = mosi_bits[0];
        half_wait(pre);
        for (int i = 0; i < nbits; i++) begin
            sclk = ~m_cpol;
            if (m_cpha) mosi = mosi_bits[i];
            else begin
                miso_bits[i] = miso;
                if (miso !== pre) unstable++;
            end
            half_wait(pre);
            sclk = m_cpol;
            if (m_cpha) begin
                miso_bits[i] = miso;
                if (miso !== pre) unstable++;
            end else if (i + 1 < nbits) mosi = mosi_bits[i + 1];
            half_wait(pre);
        end
        if (release_cs) begin
            cs_n = 1'b1;
            #(HALF);
        end
    endtask

    initial begin
        logic [15:0] got;
        int          unst;
        int          rx0, u0, r0;
        logic [1:0]  modes [0:2];
        logic [7:0]  txw   [0:2];
        logic [7:0]  rxw   [0:2];
        modes = '{2'b01, 2'b10, 2'b11};
        txw   = '{8'b11011000, 8'b01011001, 8'b00011011};
        rxw   = '{8'b01110110, 8'b00000000, 8'b11111111};

        // reset values
        #23;
        check("reset_outputs", {miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy}, 6'b001000);
        check("reset_rx_data", rx_data, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        #(HALF);

        // mode 0, single word
        rx0 = rxv_cnt; u0 = und_cnt;
        push_tx(8'b00001111);
        spi_xfer(1'b0, 1'b0, 8, 16'h00AA, 1'b1, got, unst);
        check("m0_miso_word", got[7:0], 8'b00001111);
        check("m0_rx_data", rx_data, 8'b10101010);
        check("m0_rx_strobes", rxv_cnt - rx0, 1);
        check("m0_end_reload_underrun", und_cnt - u0, 1);
        check("m0_miso_stable", unst, 0);
        check("m0_idle_after_cs", {busy, miso_oe}, 2'b00);

        // modes 1..3
        for (int m = 0; m < 3; m++) begin
            rx0 = rxv_cnt;
            push_tx(txw[m]);
            spi_xfer(modes[m][1], modes[m][0], 8, {8'h00, rxw[m]}, 1'b1, got, unst);
            check("mode_miso_word", got[7:0], txw[m]);
            check("mode_rx_data", rx_data, rxw[m]);
            check("mode_rx_strobes", rxv_cnt - rx0, 1);
            check("mode_miso_stable", unst, 0);
        end

        // two words back-to-back, second word buffered mid-first-word
        rx0 = rxv_cnt; u0 = und_cnt; r0 = rdy_rise;
        push_tx(8'h96);
        fork
            spi_xfer(1'b0, 1'b0, 16, 16'hE75A, 1'b1, got, unst);
            begin
                #(HALF * 6);
                push_tx(8'h3E);
            end
        join
        check("b2b_miso_words", got, 16'h3E96);
        check("b2b_rx_strobes", rxv_cnt - rx0, 2);
        check("b2b_rx_word0", rx_log[rx0 % 4], 8'h5A);
        check("b2b_rx_word1", rx_log[(rx0 + 1) % 4], 8'hE7);
        check("b2b_tx_ready_rises", rdy_rise - r0, 2);
        check("b2b_underruns", und_cnt - u0, 1);

        // nothing buffered at word start: fill word goes out
        rx0 = rxv_cnt; u0 = und_cnt;
        fork
            spi_xfer(1'b0, 1'b0, 8, 16'h0081, 1'b1, got, unst);
            begin
                #(HALF * 8);
                push_tx(8'h77);
            end
        join
        check("fill_miso_word", got[7:0], 8'hA5);
        check("fill_underrun_once", und_cnt - u0, 1);
        check("fill_rx_data", rx_data, 8'h81);
        check("fill_tx_ready", tx_ready, 1'b1);

        // CS_ released after 5 bits
        rx0 = rxv_cnt;
        push_tx(8'hF0);
        spi_xfer(1'b0, 1'b0, 5, 16'h001F, 1'b1, got, unst);
        check("abort_partial_miso", got[4:0], 5'b10000);
        check("abort_no_rx_strobe", rxv_cnt - rx0, 0);
        check("abort_rx_data_held", rx_data, 8'h81);
        check("abort_idle", {busy, tx_ready}, 2'b01);
        push_tx(8'h5C);
        spi_xfer(1'b0, 1'b0, 8, 16'h002B, 1'b1, got, unst);
        check("after_abort_miso", got[7:0], 8'h5C);
        check("after_abort_rx", rx_data, 8'h2B);

        // reset mid-word
        rx0 = rxv_cnt; u0 = und_cnt;
        push_tx(8'h11);
        spi_xfer(1'b0, 1'b0, 4, 16'h000F, 1'b0, got, unst);
        check("pre_reset_busy", busy, 1'b1);
        reset_n = 1'b0;
        #25;
        check("midreset_outputs", {miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy}, 6'b001000);
        check("midreset_rx_data", rx_data, 8'h00);
        cs_n = 1'b1;
        sclk = 1'b0;
        #50;
        reset_n = 1'b1;
        #(HALF);
        check("postreset_outputs", {miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy}, 6'b001000);
        check("postreset_no_strobes", (rxv_cnt - rx0) + (und_cnt - u0), 0);
        push_tx(8'h3C);
        spi_xfer(1'b0, 1'b0, 8, 16'h00C3, 1'b1, got, unst);
        check("postreset_miso", got[7:0], 8'h3C);
        check("postreset_rx", rx_data, 8'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
